// File: rtl/approx_add_arbiter.sv
// approx_add_arbiter: two requesters share one approximate adder through a
// round-robin arbiter and a 2-stage pipeline (S1 operands, S2 result).
// Saturating counters track completed responses and accumulated error.
//
// Handshake rule used on every port: a transfer happens on a rising edge where
// valid and ready are both high. A producer keeps valid (and its data) steady
// until that transfer. req_ready may depend combinationally on req_valid and
// never depends on rsp_valid.
module approx_add_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req_exact,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH:0]   rsp_sum,
  output logic [WIDTH:0]   rsp_err,
  input  logic             clr_stats,
  output logic [15:0]      op_count,
  output logic [15:0]      err_total
);

  // Arbitration state: ptr names the requester that wins a tie.
  logic             ptr;
  logic [1:0]       grant;

  // Stage 1: captured request.
  logic             s1_valid;
  logic             s1_id;
  logic             s1_exact;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  // Stage 2: result presented on the response port.
  logic             s2_valid;
  logic             s2_id;
  logic [WIDTH:0]   s2_sum;
  logic [WIDTH:0]   s2_err;

  logic             s1_move;
  logic             accept;
  logic             req_fire;
  logic             fire_id;
  logic             rsp_fire;

  // Datapath signals computed from stage-1 contents.
  logic             c2;
  logic [WIDTH-2:0] upper_sum;
  logic [WIDTH:0]   approx_sum;
  logic [WIDTH:0]   exact_sum;
  logic [WIDTH:0]   abs_diff;
  logic [WIDTH:0]   sel_sum;
  logic [WIDTH:0]   sel_err;

  logic [16:0]      err_acc;

  // Round-robin grant: a lone requester wins; on a tie ptr decides.
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // S1 empties when S2 can take its contents; S1 accepts when empty or emptying.
  assign s1_move   = s1_valid & (~s2_valid | rsp_ready);
  assign accept    = ~s1_valid | s1_move;
  assign req_ready = (accept & ~rst) ? grant : 2'b00;
  assign req_fire  = |(req_valid & req_ready);
  assign fire_id   = req_ready[1];
  assign rsp_fire  = s2_valid & rsp_ready;

  // Approximate and exact sums of the stage-1 operands, plus their distance.
  always_comb begin
    c2         = (s1_a[0] & s1_a[1]) | (s1_b[0] & s1_b[1]);
    upper_sum  = {1'b0, s1_a[WIDTH-1:2]} + {1'b0, s1_b[WIDTH-1:2]}
               + {{(WIDTH-2){1'b0}}, c2};
    approx_sum = {upper_sum, ~(s1_a[1] & s1_b[1]), ~(s1_a[0] & s1_b[0])};
    exact_sum  = {1'b0, s1_a} + {1'b0, s1_b};
    abs_diff   = (exact_sum >= approx_sum) ? (exact_sum - approx_sum)
                                           : (approx_sum - exact_sum);
    sel_sum    = s1_exact ? exact_sum : approx_sum;
    sel_err    = s1_exact ? '0 : abs_diff;
  end

  // Priority pointer flips away from whoever was just granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (req_fire) begin
      ptr <= ~fire_id;
    end
  end

  // Stage 1 register: load on a request transfer, empty when handed to S2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_id    <= 1'b0;
      s1_exact <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (req_fire) begin
      s1_valid <= 1'b1;
      s1_id    <= fire_id;
      s1_exact <= req_exact[fire_id];
      s1_a     <= fire_id ? req1_a : req0_a;
      s1_b     <= fire_id ? req1_b : req0_b;
    end else if (s1_move) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2 register: load from S1, hold under backpressure, empty on drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_id    <= 1'b0;
      s2_sum   <= '0;
      s2_err   <= '0;
    end else if (s1_move) begin
      s2_valid <= 1'b1;
      s2_id    <= s1_id;
      s2_sum   <= sel_sum;
      s2_err   <= sel_err;
    end else if (rsp_fire) begin
      s2_valid <= 1'b0;
    end
  end

  assign rsp_valid = s2_valid;
  assign rsp_id    = s2_id;
  assign rsp_sum   = s2_sum;
  assign rsp_err   = s2_err;

  // One extra bit catches overflow of the error accumulator.
  assign err_acc = {1'b0, err_total} + 17'(s2_err);

  // Saturating statistics; clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count  <= '0;
      err_total <= '0;
    end else if (clr_stats) begin
      op_count  <= '0;
      err_total <= '0;
    end else if (rsp_fire) begin
      if (op_count != 16'hFFFF) begin
        op_count <= op_count + 16'd1;
      end
      err_total <= err_acc[16] ? 16'hFFFF : err_acc[15:0];
    end
  end

endmodule

// File: tb/tb_approx_add_arbiter.sv
// Directed-vector bench for approx_add_arbiter (WIDTH = 8). Inputs change
// 1 ns after a rising edge; outputs are sampled 2 ns after it.
module tb_approx_add_arbiter;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]   req_exact;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [W:0]   rsp_sum;
  logic [W:0]   rsp_err;
  logic         clr_stats;
  logic [15:0]  op_count;
  logic [15:0]  err_total;

  int checks = 0;
  int failures = 0;

  // Expected responses: {id, sum, err}.
  logic [2*W+2:0] exp_q[$];

  approx_add_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req_exact(req_exact),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_err(rsp_err),
    .clr_stats(clr_stats), .op_count(op_count), .err_total(err_total)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_clr();
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
  endtask

  // Present one request and hold it until accepted (bounded). Entry and exit
  // are 1 ns after a rising edge; on exit the handshake edge has just passed.
  task automatic send_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ex, output logic ok);
    logic got;
    got = 1'b0;
    if (id == 0) begin req0_a = a; req0_b = b; end
    else         begin req1_a = a; req1_b = b; end
    req_exact[id] = ex;
    req_valid = (id == 0) ? 2'b01 : 2'b10;
    for (int c = 0; c < 20 && !got; c++) begin
      #1;
      got = req_ready[id];
      step();
    end
    req_valid = 2'b00;
    ok = got;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    req_valid = 2'b11;
    idle(2);
    #1;
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_id !== 1'b0) begin failures++; $display("FAIL reset_rsp_id: got %b expected 0", rsp_id); end
    checks++; if (rsp_sum !== 9'h000) begin failures++; $display("FAIL reset_rsp_sum: got %h expected 000", rsp_sum); end
    checks++; if (rsp_err !== 9'h000) begin failures++; $display("FAIL reset_rsp_err: got %h expected 000", rsp_err); end
    checks++; if (op_count !== 16'h0000) begin failures++; $display("FAIL reset_op_count: got %h expected 0000", op_count); end
    checks++; if (err_total !== 16'h0000) begin failures++; $display("FAIL reset_err_total: got %h expected 0000", err_total); end
    step();
    req_valid = 2'b00;
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_single();
    logic ok;
    rsp_ready = 1'b1;
    send_op(0, 8'h03, 8'h01, 1'b0, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL single_handshake: got %b expected 1", ok); end
    #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_latency_k1: rsp_valid got %b expected 0", rsp_valid); end
    step(); #1;
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL single_latency_k2: rsp_valid got %b expected 1", rsp_valid); end
    checks++; if (rsp_sum !== 9'h006) begin failures++; $display("FAIL single_sum: got %h expected 006", rsp_sum); end
    checks++; if (rsp_err !== 9'h002) begin failures++; $display("FAIL single_err: got %h expected 002", rsp_err); end
    checks++; if (rsp_id !== 1'b0) begin failures++; $display("FAIL single_id: got %b expected 0", rsp_id); end
    step(); #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_drain: rsp_valid got %b expected 0", rsp_valid); end
    checks++; if (op_count !== 16'd1) begin failures++; $display("FAIL single_op_count: got %0d expected 1", op_count); end
    checks++; if (err_total !== 16'd2) begin failures++; $display("FAIL single_err_total: got %0d expected 2", err_total); end
    step();
  endtask

  task automatic test_corner();
    logic ok;
    logic [W-1:0] ta[4] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    logic [W-1:0] tb[4] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    logic         te[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [W:0]   ts[4] = '{9'h1FC, 9'h003, 9'h1FE, 9'h000};
    logic [W:0]   tr[4] = '{9'h002, 9'h003, 9'h000, 9'h000};
    rsp_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      send_op(1, ta[v], tb[v], te[v], ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL corner_handshake[%0d]: got %b expected 1", v, ok); end
      for (int c = 0; c < 10; c++) begin
        #1;
        if (rsp_valid) break;
        step();
      end
      checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL corner_valid[%0d]: got %b expected 1", v, rsp_valid); end
      checks++; if (rsp_sum !== ts[v]) begin failures++; $display("FAIL corner_sum[%0d]: got %h expected %h", v, rsp_sum, ts[v]); end
      checks++; if (rsp_err !== tr[v]) begin failures++; $display("FAIL corner_err[%0d]: got %h expected %h", v, rsp_err, tr[v]); end
      checks++; if (rsp_id !== 1'b1) begin failures++; $display("FAIL corner_id[%0d]: got %b expected 1", v, rsp_id); end
      step();
    end
    idle(2);
  endtask

  // ptr is 0 here (last grant went to requester 1), so grants start at 0.
  task automatic test_fairness();
    int issued, received;
    logic [1:0] exp_grant;
    logic [2*W+2:0] e;
    pulse_clr();
    req0_a = 8'h10; req0_b = 8'h20;
    req1_a = 8'h40; req1_b = 8'h05;
    req_exact = 2'b11;
    rsp_ready = 1'b1;
    issued = 0; received = 0;
    for (int c = 0; c < 40 && (issued < 8 || received < 8); c++) begin
      req_valid = (issued < 8) ? 2'b11 : 2'b00;
      #1;
      if (issued < 8) begin
        exp_grant = (issued % 2 == 0) ? 2'b01 : 2'b10;
        checks++; if (req_ready !== exp_grant) begin failures++; $display("FAIL fair_grant[%0d]: got %b expected %b", issued, req_ready, exp_grant); end
        if (req_ready == 2'b01) exp_q.push_back({1'b0, 9'h030, 9'h000});
        if (req_ready == 2'b10) exp_q.push_back({1'b1, 9'h045, 9'h000});
        if (req_ready != 2'b00) issued++;
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++; failures++; $display("FAIL fair_extra_rsp: got id %b expected none", rsp_id);
        end else begin
          e = exp_q.pop_front();
          checks++; if ({rsp_id, rsp_sum, rsp_err} !== e) begin failures++; $display("FAIL fair_rsp[%0d]: got %h expected %h", received, {rsp_id, rsp_sum, rsp_err}, e); end
        end
        received++;
      end
      step();
    end
    req_valid = 2'b00;
    checks++; if (received !== 8) begin failures++; $display("FAIL fair_rsp_count: got %0d expected 8", received); end
    checks++; if (op_count !== 16'd8) begin failures++; $display("FAIL fair_op_count: got %0d expected 8", op_count); end
    exp_q.delete();
    idle(2);
  endtask

  // ptr is 0 again after eight alternating grants.
  task automatic test_backpressure();
    int issued, received;
    logic [2*W+2:0] e;
    logic [1:0] exp_rdy[10] = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b00,
                                2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    req0_a = 8'h03; req0_b = 8'h01;
    req1_a = 8'hFF; req1_b = 8'hFF;
    req_exact = 2'b00;
    issued = 0; received = 0;
    for (int c = 0; c < 10; c++) begin
      req_valid = (c < 5) ? 2'b11 : 2'b00;
      rsp_ready = (c < 5) ? 1'b0 : 1'b1;
      #1;
      checks++; if (req_ready !== exp_rdy[c]) begin failures++; $display("FAIL bp_req_ready[%0d]: got %b expected %b", c, req_ready, exp_rdy[c]); end
      if (req_ready == 2'b01) begin exp_q.push_back({1'b0, 9'h006, 9'h002}); issued++; end
      if (req_ready == 2'b10) begin exp_q.push_back({1'b1, 9'h1FC, 9'h002}); issued++; end
      if (c >= 2 && c <= 4) begin
        checks++; if ({rsp_valid, rsp_id, rsp_sum, rsp_err} !== {1'b1, 1'b0, 9'h006, 9'h002}) begin
          failures++; $display("FAIL bp_hold[%0d]: got %h expected %h", c, {rsp_valid, rsp_id, rsp_sum, rsp_err}, {1'b1, 1'b0, 9'h006, 9'h002});
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++; $display("FAIL bp_extra_rsp: got id %b expected none", rsp_id);
        end else begin
          e = exp_q.pop_front();
          checks++; if ({rsp_id, rsp_sum, rsp_err} !== e) begin failures++; $display("FAIL bp_rsp[%0d]: got %h expected %h", received, {rsp_id, rsp_sum, rsp_err}, e); end
        end
        received++;
      end
      step();
    end
    checks++; if (issued !== 2) begin failures++; $display("FAIL bp_in_flight: got %0d expected 2", issued); end
    checks++; if (received !== 2) begin failures++; $display("FAIL bp_delivered: got %0d expected 2", received); end
    exp_q.delete();
    idle(1);
  endtask

  task automatic test_stats();
    logic ok;
    rsp_ready = 1'b1;
    pulse_clr();
    send_op(0, 8'h03, 8'h01, 1'b0, ok);
    send_op(0, 8'h00, 8'h00, 1'b0, ok);
    send_op(0, 8'hFF, 8'hFF, 1'b0, ok);
    idle(4);
    checks++; if (op_count !== 16'd3) begin failures++; $display("FAIL stats_op_count: got %0d expected 3", op_count); end
    checks++; if (err_total !== 16'd7) begin failures++; $display("FAIL stats_err_total: got %0d expected 7", err_total); end
    send_op(0, 8'h03, 8'h01, 1'b0, ok);
    step();
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL stats_clr_setup: rsp_valid got %b expected 1", rsp_valid); end
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    checks++; if (op_count !== 16'd0) begin failures++; $display("FAIL stats_clr_op_count: got %0d expected 0", op_count); end
    checks++; if (err_total !== 16'd0) begin failures++; $display("FAIL stats_clr_err_total: got %0d expected 0", err_total); end
    idle(2);
  endtask

  // 21845 ops of error 3 reach exactly 16'hFFFF; one more must clamp.
  task automatic test_saturation();
    int cnt;
    pulse_clr();
    req0_a = 8'h00; req0_b = 8'h00;
    req_exact = 2'b00;
    rsp_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 30000 && cnt < 21846; c++) begin
      req_valid = 2'b01;
      #1;
      if (req_ready[0]) cnt++;
      step();
    end
    req_valid = 2'b00;
    checks++; if (cnt !== 21846) begin failures++; $display("FAIL sat_ops_issued: got %0d expected 21846", cnt); end
    idle(4);
    checks++; if (err_total !== 16'hFFFF) begin failures++; $display("FAIL sat_err_total: got %h expected ffff", err_total); end
    checks++; if (op_count !== 16'd21846) begin failures++; $display("FAIL sat_op_count: got %0d expected 21846", op_count); end
  endtask

  task automatic test_reset_mid();
    req0_a = 8'h03; req0_b = 8'h01;
    req1_a = 8'h10; req1_b = 8'h22;
    req_exact = 2'b01;
    rsp_ready = 1'b0;
    req_valid = 2'b11;
    idle(3);
    #1;
    checks++; if ({rsp_valid, req_ready} !== 3'b100) begin failures++; $display("FAIL rstmid_full: got %b expected 100", {rsp_valid, req_ready}); end
    rst = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL rstmid_req_ready: got %b expected 00", req_ready); end
    checks++; if ({rsp_valid, rsp_id} !== 2'b00) begin failures++; $display("FAIL rstmid_valid_id: got %b expected 00", {rsp_valid, rsp_id}); end
    checks++; if ({rsp_sum, rsp_err} !== 18'h0) begin failures++; $display("FAIL rstmid_sum_err: got %h expected 0", {rsp_sum, rsp_err}); end
    checks++; if ({op_count, err_total} !== 32'h0) begin failures++; $display("FAIL rstmid_counters: got %h expected 0", {op_count, err_total}); end
    step();
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    rst = 1'b0;
    idle(3);
    #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rstmid_no_ghost: rsp_valid got %b expected 0", rsp_valid); end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 2'b00;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    req_exact = 2'b00;
    rsp_ready = 1'b0;
    clr_stats = 1'b0;
    test_reset();
    test_single();
    test_corner();
    test_fairness();
    test_backpressure();
    test_stats();
    test_saturation();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
